// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci ROM sequencer.
package fib_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 6;
  localparam int DEPTH_DEF  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DATA_W_DEF-1:0] FIB_SEQ [DEPTH_DEF] = '{
    6'd0, 6'd1, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34
  };
endpackage

// File: rtl/fib_check.sv
// Fibonacci recurrence checker: keeps the last two words and flags any word
// that differs from their (DATA_W+1)-bit sum; err is sticky until clear.
module fib_check
  import fib_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              idx_ge2,
  input  logic [DATA_W-1:0] data,
  output logic              err
);
  logic [DATA_W-1:0] prev1;
  logic [DATA_W-1:0] prev2;
  logic [DATA_W:0]   sum;

  // Extra bit keeps an overflowing sum from aliasing onto a legal word.
  assign sum = {1'b0, prev1} + {1'b0, prev2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev1 <= '0;
      prev2 <= '0;
      err   <= 1'b0;
    end else if (clear) begin
      prev1 <= '0;
      prev2 <= '0;
      err   <= 1'b0;
    end else if (enable) begin
      if (idx_ge2 && (sum != {1'b0, data}))
        err <= 1'b1;
      prev2 <= prev1;
      prev1 <= data;
    end
  end
endmodule

// File: rtl/fib_rom_reader.sv
// Walks a combinational ROM from 0 to DEPTH-1 on start and offers each word
// on a valid/ready stream (one word per 2 cycles at best), checking the recurrence.
module fib_rom_reader
  import fib_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] TWO       = ADDR_W'(2);

  state_t state;
  logic   chk_clear;
  logic   chk_en;

  assign chk_clear = (state == IDLE) && start;
  assign chk_en    = (state == FETCH);

  fib_check #(.DATA_W(DATA_W)) u_check (
    .clk     (clk),
    .rst     (rst),
    .clear   (chk_clear),
    .enable  (chk_en),
    .idx_ge2 (rom_addr >= TWO),
    .data    (rom_data),
    .err     (err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rom_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rom_addr <= '0;
          done     <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          out_data  <= rom_data;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          // Word and address stay frozen until the consumer takes the word.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (rom_addr == LAST_ADDR) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          rom_addr <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
